// File: rtl/fifo_stream_reader.sv
// Drains a FIFO read port into a valid/ready stream through a 2-entry registered
// skid buffer, with a flush mode that discards everything buffered or in flight.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data_rd,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic                  flush_busy,
    output logic [15:0]           rd_count
);

    typedef enum logic {
        NORMAL = 1'b0,
        FLUSH  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [1:0]            occ;
    logic [1:0]            occ_next;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] head_next;
    logic [DATA_WIDTH-1:0] tail;
    logic [DATA_WIDTH-1:0] tail_next;
    logic                  handshake;
    logic                  capture;
    logic [2:0]            pending;

    assign m_valid   = (occ != 2'd0);
    assign m_data    = head;
    assign handshake = m_valid && m_ready;

    // Words already owed to the buffer after this cycle's handshake retires.
    assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, handshake};

    // Returned FIFO data is only ever kept in NORMAL; in FLUSH it is dropped on the floor.
    assign capture = (state == NORMAL) &&
                     ((RD_LATENCY == 0) ? fifo_rd_en : inflight);

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state <= NORMAL;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        flush_busy = (state == FLUSH);
        unique case (state)
            NORMAL: begin
                fifo_rd_en = !fifo_empty && (pending < 3'd2);
                if (flush) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                fifo_rd_en = !fifo_empty;
                if (fifo_empty && !inflight) begin
                    state_next = NORMAL;
                end
            end
            default: state_next = NORMAL;
        endcase
        if (rst) begin
            fifo_rd_en = 1'b0;
        end
    end

    always_comb begin
        occ_next  = occ;
        head_next = head;
        tail_next = tail;
        unique case ({handshake, capture})
            2'b10: begin
                head_next = tail;
                occ_next  = occ - 2'd1;
            end
            2'b01: begin
                if (occ == 2'd0) begin
                    head_next = fifo_data_rd;
                end else begin
                    tail_next = fifo_data_rd;
                end
                occ_next = occ + 2'd1;
            end
            2'b11: begin
                if (occ == 2'd1) begin
                    head_next = fifo_data_rd;
                end else begin
                    head_next = tail;
                    tail_next = fifo_data_rd;
                end
            end
            default: ;
        endcase
        // A flush still lets a coincident handshake retire, but empties the buffer.
        if (flush || state == FLUSH) begin
            occ_next = 2'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            head     <= '0;
            rd_count <= 16'd0;
        end else begin
            occ      <= occ_next;
            inflight <= (RD_LATENCY == 1) && fifo_rd_en;
            head     <= head_next;
            if (handshake) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end

    // NOTE: tail is pure storage qualified by occ, so it carries no reset.
    always_ff @(posedge rd_clk) begin
        tail <= tail_next;
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: one reader with a registered FIFO (RD_LATENCY=1), one with a
// fall-through FIFO (RD_LATENCY=0), both fed from simple FIFO models.
module tb_fifo_stream_reader;

    logic rd_clk = 1'b0;
    logic rst;
    always #5 rd_clk = ~rd_clk;

    // Latency-1 reader signals
    logic        empty1, rd_en1, valid1, ready1, flush1, busy1;
    logic [7:0]  fdata1 = 8'h00;
    logic [7:0]  data1;
    logic [15:0] cnt1;
    // Latency-0 reader signals
    logic        empty0, rd_en0, valid0, ready0, flush0, busy0;
    logic [7:0]  fdata0;
    logic [7:0]  data0;
    logic [15:0] cnt0;

    fifo_stream_reader #(.DATA_WIDTH(8), .RD_LATENCY(1)) dut1 (
        .rd_clk(rd_clk), .rst(rst), .fifo_empty(empty1), .fifo_rd_en(rd_en1),
        .fifo_data_rd(fdata1), .m_valid(valid1), .m_ready(ready1), .m_data(data1),
        .flush(flush1), .flush_busy(busy1), .rd_count(cnt1)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .RD_LATENCY(0)) dut0 (
        .rd_clk(rd_clk), .rst(rst), .fifo_empty(empty0), .fifo_rd_en(rd_en0),
        .fifo_data_rd(fdata0), .m_valid(valid0), .m_ready(ready0), .m_data(data0),
        .flush(flush0), .flush_busy(busy0), .rd_count(cnt0)
    );

    // FIFO models: 256-entry rings, written by the stimulus, popped on rd_en
    logic [7:0] mem1 [256];
    logic [7:0] mem0 [256];
    logic [7:0] wp1 = 8'd0, rp1 = 8'd0;
    logic [7:0] wp0 = 8'd0, rp0 = 8'd0;

    assign empty1 = (wp1 == rp1);
    assign empty0 = (wp0 == rp0);
    assign fdata0 = mem0[rp0];

    always @(posedge rd_clk) begin
        if (rd_en1 && !empty1) begin
            fdata1 <= mem1[rp1];
            rp1    <= rp1 + 8'd1;
        end
        if (rd_en0 && !empty0) begin
            rp0 <= rp0 + 8'd1;
        end
    end

    // Monitor, sampled on the falling edge
    int         cyc = 0;
    int         pops1 = 0, hs1 = 0, viol = 0;
    int         first_rd1 = -1, first_val1 = -1;
    int         first_rd0 = -1, first_val0 = -1;
    logic [7:0] got1[$];
    int         got1_cyc[$];
    logic [7:0] got0[$];

    always @(posedge rd_clk) cyc <= cyc + 1;

    always @(negedge rd_clk) begin
        if ((rd_en1 && empty1) || (rd_en0 && empty0)) viol <= viol + 1;
        if (rd_en1) begin
            pops1 <= pops1 + 1;
            if (first_rd1 < 0) first_rd1 <= cyc;
        end
        if (valid1 && first_val1 < 0) first_val1 <= cyc;
        if (valid1 && ready1) begin
            got1.push_back(data1);
            got1_cyc.push_back(cyc);
            hs1 <= hs1 + 1;
        end
        if (rd_en0 && first_rd0 < 0) first_rd0 <= cyc;
        if (valid0 && first_val0 < 0) first_val0 <= cyc;
        if (valid0 && ready0) got0.push_back(data0);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic push1(input logic [7:0] d);
        mem1[wp1] = d;
        wp1 = wp1 + 8'd1;
    endtask

    task automatic push0(input logic [7:0] d);
        mem0[wp0] = d;
        wp0 = wp0 + 8'd1;
    endtask

    initial begin
        int         base;
        int         p0;
        int         n;
        int         k;
        int         hbase;
        int         errs;
        logic [7:0] fill;

        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        rst = 1'b1;
        ready1 = 1'b0; flush1 = 1'b0;
        ready0 = 1'b0; flush0 = 1'b0;
        step(2);
        check("rst_rd_en", rd_en1, 0);
        check("rst_valid", valid1, 0);
        check("rst_data", data1, 0);
        check("rst_busy", busy1, 0);
        check("rst_count", cnt1, 0);
        check("rst_count_l0", cnt0, 0);
        rst = 1'b0;
        step(1);

        // Fall-through FIFO: one word, valid one cycle after the pop
        ready0 = 1'b1;
        push0(8'h5A);
        step(4);
        check("l0_latency", first_val0 - first_rd0, 1);
        check("l0_words", got0.size(), 1);
        check("l0_data", got0[0], 8'h5A);
        check("l0_count", cnt0, 1);

        // Streaming 0x01..0x08 with m_ready held high
        ready1 = 1'b1;
        for (int i = 1; i <= 8; i++) push1(8'(i));
        step(14);
        check("stream_latency", first_val1 - first_rd1, 2);
        check("stream_words", got1.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("stream_w%0d", i), got1[i], i + 1);
        check("stream_back_to_back", got1_cyc[7] - got1_cyc[0], 7);
        check("stream_count", cnt1, 8);

        // Backpressure: only two pops fit the buffer, head holds still
        ready1 = 1'b0;
        base = got1.size();
        p0 = pops1;
        push1(8'h11); push1(8'h22); push1(8'h33); push1(8'h44);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (valid1 && data1 !== 8'h11) errs++;
        end
        check("bp_pops", pops1 - p0, 2);
        check("bp_valid", valid1, 1);
        check("bp_head", data1, 8'h11);
        check("bp_stable", errs, 0);
        ready1 = 1'b1;
        step(8);
        check("bp_words", got1.size() - base, 4);
        check("bp_w0", got1[base], 8'h11);
        check("bp_w1", got1[base + 1], 8'h22);
        check("bp_w2", got1[base + 2], 8'h33);
        check("bp_w3", got1[base + 3], 8'h44);
        check("bp_count", cnt1, 12);

        // Flush with 2 buffered + 5 in FIFO, coinciding with one handshake
        ready1 = 1'b0;
        base = got1.size();
        for (int i = 0; i < 7; i++) push1(8'(8'h31 + i));
        step(6);
        flush1 = 1'b1;
        ready1 = 1'b1;
        step(1);
        flush1 = 1'b0;
        check("fl_valid_drop", valid1, 0);
        check("fl_busy", busy1, 1);
        check("fl_hs_words", got1.size() - base, 1);
        check("fl_hs_data", got1[base], 8'h31);
        n = 0;
        errs = 0;
        while (busy1 && n < 40) begin
            step(1);
            n++;
            if (valid1) errs++;
        end
        check("fl_done", busy1, 0);
        check("fl_fifo_empty", empty1, 1);
        check("fl_no_valid", errs, 0);
        check("fl_count", cnt1, 13);
        push1(8'hAA);
        step(4);
        check("fl_after_words", got1.size() - base, 2);
        check("fl_after_data", got1[base + 1], 8'hAA);
        check("fl_after_count", cnt1, 14);

        // Reset while a word is buffered and another is in flight
        ready1 = 1'b0;
        base = got1.size();
        for (int i = 0; i < 5; i++) push1(8'(8'h41 + i));
        step(2);
        check("mr_pre_valid", valid1, 1);
        rst = 1'b1;
        #1;
        check("mr_rd_en", rd_en1, 0);
        check("mr_valid", valid1, 0);
        check("mr_data", data1, 0);
        check("mr_busy", busy1, 0);
        check("mr_count", cnt1, 0);
        step(2);
        rst = 1'b0;
        ready1 = 1'b1;
        step(8);
        check("mr_words", got1.size() - base, 3);
        check("mr_w0", got1[base], 8'h43);
        check("mr_w1", got1[base + 1], 8'h44);
        check("mr_w2", got1[base + 2], 8'h45);
        check("mr_count_after", cnt1, 3);

        // Counter wrap: 65535 handshakes from reset, then one more
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        base = got1.size();
        hbase = hs1;
        ready1 = 1'b1;
        k = 0;
        n = 0;
        while ((hs1 - hbase) < 65535 && n < 70000) begin
            fill = wp1 - rp1;
            if (fill < 8'd8) begin
                push1(8'(k));
                k++;
            end
            step(1);
            n++;
        end
        ready1 = 1'b0;
        check("wrap_hs", hs1 - hbase, 65535);
        check("wrap_ffff", cnt1, 16'hFFFF);
        errs = 0;
        for (int i = 0; i < got1.size() - base; i++) begin
            if (got1[base + i] !== 8'(i)) errs++;
        end
        check("wrap_order", errs, 0);
        check("wrap_valid", valid1, 1);
        ready1 = 1'b1;
        step(1);
        ready1 = 1'b0;
        check("wrap_zero", cnt1, 16'h0000);
        step(2);
        check("rd_en_while_empty", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
